// File: rtl/frame_buffer_arbiter.sv
// Frame buffer arbiter: shares one single-port, double-banked pixel RAM
// between the display scan reader (front bank, priority) and a host port
// (back bank). Includes a zero-fill clear engine and frame-synchronous swap.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | host_req may be served; clear engine inactive
// CLEAR  | clear engine owns the host side, zero-filling the back bank
module frame_buffer_arbiter #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 24,
    parameter int MAX_HOST_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_valid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              host_clear,
    input  logic              host_swap,
    input  logic              frame_start,
    output logic              clear_busy,
    output logic              swap_pend,
    output logic              swap_done,
    output logic              front_bank,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int WAIT_W = $clog2(MAX_HOST_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_HOST_WAIT);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clear_ctr;
    logic [WAIT_W-1:0] wait_ctr;
    logic [DATA_W-1:0] disp_hold;
    logic [DATA_W-1:0] host_hold;
    logic              host_side_req;
    logic              host_win;
    logic              clear_win;
    logic              do_swap;

    assign clear_busy = (state == ST_CLEAR);

    // Arbitration and RAM strobe generation; nothing is issued while in reset
    always_comb begin
        host_side_req = ~rst & (clear_busy | host_req);
        host_win      = host_side_req & (~disp_req | (wait_ctr == WAIT_MAX));
        disp_gnt      = ~rst & disp_req & ~host_win;
        clear_win     = host_win & clear_busy;
        host_gnt      = host_win & ~clear_busy;
        ram_en        = disp_gnt | host_win;
        ram_we        = clear_win | (host_gnt & host_we);
        ram_addr      = '0;
        ram_wdata     = '0;
        if (disp_gnt) begin
            ram_addr = {front_bank, disp_addr};
        end else if (clear_win) begin
            ram_addr = {~front_bank, clear_ctr};
        end else if (host_gnt) begin
            ram_addr = {~front_bank, host_addr};
            if (host_we) begin
                ram_wdata = host_wdata;
            end
        end
    end

    // Starvation counter: counts host-side losses, forces a slot at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_ctr <= '0;
        end else if (host_win) begin
            wait_ctr <= '0;
        end else if (host_side_req) begin
            wait_ctr <= wait_ctr + 1'b1;
        end
    end

    // Clear engine: one zero write per host-side win, leaves after the last address
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            clear_ctr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (host_clear) begin
                        state     <= ST_CLEAR;
                        clear_ctr <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clear_win) begin
                        clear_ctr <= clear_ctr + 1'b1;
                        if (clear_ctr == '1) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A swap is only applied at a frame boundary and never while clearing,
    // so the display never sees a partially cleared bank
    assign do_swap = frame_start & (swap_pend | host_swap) & ~clear_busy;

    // Bank swap bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            front_bank <= 1'b0;
            swap_pend  <= 1'b0;
            swap_done  <= 1'b0;
        end else begin
            swap_done <= do_swap;
            if (do_swap) begin
                front_bank <= ~front_bank;
                swap_pend  <= 1'b0;
            end else if (host_swap) begin
                swap_pend <= 1'b1;
            end
        end
    end

    // Read-valid tracking and last-read hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_valid <= 1'b0;
            host_valid <= 1'b0;
            disp_hold  <= '0;
            host_hold  <= '0;
        end else begin
            disp_valid <= disp_gnt;
            host_valid <= host_gnt & ~host_we;
            if (disp_valid) begin
                disp_hold <= ram_rdata;
            end
            if (host_valid) begin
                host_hold <= ram_rdata;
            end
        end
    end

    // RAM data arrives one cycle after the grant; present it live on the
    // valid cycle, then keep showing it until the next read completes
    assign disp_rdata = disp_valid ? ram_rdata : disp_hold;
    assign host_rdata = host_valid ? ram_rdata : host_hold;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a behavioural 1-cycle RAM.
module tb_frame_buffer_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_valid;
    logic [DATA_W-1:0] disp_rdata;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_valid;
    logic [DATA_W-1:0] host_rdata;
    logic              host_clear;
    logic              host_swap;
    logic              frame_start;
    logic              clear_busy;
    logic              swap_pend;
    logic              swap_done;
    logic              front_bank;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W:0]   ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] mem [0:(1<<(ADDR_W+1))-1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    frame_buffer_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOST_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_valid(disp_valid), .disp_rdata(disp_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_valid(host_valid),
        .host_rdata(host_rdata), .host_clear(host_clear), .host_swap(host_swap),
        .frame_start(frame_start), .clear_busy(clear_busy), .swap_pend(swap_pend),
        .swap_done(swap_done), .front_bank(front_bank),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // single-port RAM, registered read
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int busy_cyc, n_wr, n_bad, n_hg;

    initial begin
        for (int i = 0; i < (1 << (ADDR_W + 1)); i++) mem[i] = '0;
        mem[11'h005] = 24'hFF0000;
        mem[11'h3FF] = 24'hABCDEF;
        ram_rdata   = '0;
        rst = 1'b1; disp_req = 0; disp_addr = '0; host_req = 0; host_we = 0;
        host_addr = '0; host_wdata = '0; host_clear = 0; host_swap = 0; frame_start = 0;
        tick(); tick();

        // reset state
        check("rst_front_bank", 32'(front_bank), 0);
        check("rst_clear_busy", 32'(clear_busy), 0);
        check("rst_swap_pend",  32'(swap_pend), 0);
        check("rst_swap_done",  32'(swap_done), 0);
        check("rst_disp_valid", 32'(disp_valid), 0);
        check("rst_ram_en",     32'(ram_en), 0);
        check("rst_disp_rdata", 32'(disp_rdata), 0);
        rst = 1'b0;
        tick();

        // 1: display read of front bank
        disp_req = 1; disp_addr = 10'h005; #1;
        check("t1_disp_gnt",  32'(disp_gnt), 1);
        check("t1_ram_addr",  32'(ram_addr), 32'h005);
        check("t1_ram_we",    32'(ram_we), 0);
        tick();
        disp_req = 0; #1;
        check("t1_disp_valid", 32'(disp_valid), 1);
        check("t1_disp_rdata", 32'(disp_rdata), 32'hFF0000);
        tick();
        check("t1_valid_drop", 32'(disp_valid), 0);
        check("t1_rdata_hold", 32'(disp_rdata), 32'hFF0000);

        // 2: contention, host forced a slot after 4 losses
        disp_req = 1; disp_addr = 10'h001; host_req = 1; host_we = 0; host_addr = 10'h002;
        for (int i = 0; i < 15; i++) begin
            #1;
            check($sformatf("t2_host_gnt_%0d", i), 32'(host_gnt), 32'((i % 5) == 4));
            check($sformatf("t2_disp_gnt_%0d", i), 32'(disp_gnt), 32'((i % 5) != 4));
            check($sformatf("t2_host_valid_%0d", i), 32'(host_valid),
                  32'(i > 0 && ((i - 1) % 5) == 4));
            tick();
        end
        disp_req = 0; host_req = 0;
        tick();

        // 3: host write, swap, display reads new front bank
        host_req = 1; host_we = 1; host_addr = 10'h3FF; host_wdata = 24'h00FF00; #1;
        check("t3_host_gnt",   32'(host_gnt), 1);
        check("t3_ram_we",     32'(ram_we), 1);
        check("t3_ram_addr",   32'(ram_addr), 32'h7FF);
        check("t3_ram_wdata",  32'(ram_wdata), 32'h00FF00);
        tick();
        host_req = 0;
        check("t3_no_hvalid",  32'(host_valid), 0);
        host_swap = 1;
        tick();
        host_swap = 0;
        check("t3_swap_pend",  32'(swap_pend), 1);
        check("t3_front_old",  32'(front_bank), 0);
        frame_start = 1;
        tick();
        frame_start = 0;
        check("t3_front_new",  32'(front_bank), 1);
        check("t3_swap_done",  32'(swap_done), 1);
        check("t3_pend_clr",   32'(swap_pend), 0);
        tick();
        check("t3_done_pulse", 32'(swap_done), 0);
        disp_req = 1; disp_addr = 10'h3FF; #1;
        check("t3_disp_addr",  32'(ram_addr), 32'h7FF);
        tick();
        disp_req = 0;
        check("t3_disp_rdata", 32'(disp_rdata), 32'h00FF00);

        // 4: clear of back bank 0, host blocked meanwhile
        host_clear = 1;
        tick();
        host_clear = 0;
        check("t4_clear_busy", 32'(clear_busy), 1);
        host_req = 1; host_we = 1; host_addr = 10'h010; host_wdata = 24'h123456;
        busy_cyc = 0; n_wr = 0; n_bad = 0; n_hg = 0;
        for (int i = 0; i < 2000 && clear_busy; i++) begin
            if (host_gnt) n_hg++;
            if (ram_en && ram_we && !ram_addr[ADDR_W] && ram_wdata == '0 &&
                ram_addr[ADDR_W-1:0] == ADDR_W'(busy_cyc)) n_wr++;
            else n_bad++;
            busy_cyc++;
            tick();
        end
        check("t4_busy_cycles", 32'(busy_cyc), 1024);
        check("t4_zero_writes", 32'(n_wr), 1024);
        check("t4_bad_cycles",  32'(n_bad), 0);
        check("t4_host_blocked", 32'(n_hg), 0);
        check("t4_clear_done",  32'(clear_busy), 0);
        check("t4_host_after",  32'(host_gnt), 1);
        check("t4_host_addr",   32'(ram_addr), 32'h010);
        tick();
        host_req = 0;
        check("t4_mem_005",  32'(mem[11'h005]), 0);
        check("t4_mem_3ff",  32'(mem[11'h3FF]), 0);
        check("t4_mem_7ff",  32'(mem[11'h7FF]), 32'h00FF00);
        check("t4_mem_010",  32'(mem[11'h010]), 32'h123456);

        // 5: swap requested during clear waits for clear completion
        host_clear = 1;
        tick();
        host_clear = 0;
        host_swap = 1;
        tick();
        host_swap = 0;
        check("t5_swap_pend", 32'(swap_pend), 1);
        frame_start = 1;
        tick();
        frame_start = 0;
        check("t5_no_toggle", 32'(front_bank), 1);
        check("t5_no_done",   32'(swap_done), 0);
        check("t5_still_pend", 32'(swap_pend), 1);
        for (int i = 0; i < 1100 && clear_busy; i++) tick();
        check("t5_clear_done", 32'(clear_busy), 0);
        frame_start = 1;
        tick();
        frame_start = 0;
        check("t5_toggle",    32'(front_bank), 0);
        check("t5_swap_done", 32'(swap_done), 1);

        // 6: reset mid-clear with a swap pending
        host_clear = 1;
        tick();
        host_clear = 0;
        host_swap = 1;
        tick();
        host_swap = 0;
        for (int i = 0; i < 255; i++) tick();
        check("t6_ctr_100",  32'(ram_addr), 32'h500);
        check("t6_pend",     32'(swap_pend), 1);
        rst = 1;
        tick();
        rst = 0; #1;
        check("t6_clear_busy", 32'(clear_busy), 0);
        check("t6_front",      32'(front_bank), 0);
        check("t6_swap_pend",  32'(swap_pend), 0);
        check("t6_swap_done",  32'(swap_done), 0);
        check("t6_ram_en",     32'(ram_en), 0);
        check("t6_ram_addr",   32'(ram_addr), 0);
        check("t6_disp_rdata", 32'(disp_rdata), 0);
        check("t6_host_rdata", 32'(host_rdata), 0);
        tick();
        check("t6_stays_idle", 32'(clear_busy), 0);
        check("t6_no_access",  32'(ram_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
